mmio_input_port: RTL and testbench
==================================

# mmio_input_port

Memory-mapped input peripheral for the RISC-V core's I/O window at 0x4000_0xxx. It is the read side of the board I/O: the core already writes LEDs and HEX displays, and this block lets the core read them back. It synchronises and debounces the raw `SW` and `KEY` pins, captures sticky change and press events, and returns register contents on a combinational read port. That port sits beside `Data_memory` in the MEM stage.

## Interface
- `XLEN`, 32: data and address width.
- `DEBOUNCE_CYCLES`, 50000: sample-tick period in clocks (1 ms at 50 MHz); minimum 2.
- `clock` input 1: single clock; all state is on its rising edge.
- `reset` input 1: asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `SW` input 10: raw slide switches, asynchronous, 1 = on.
- `KEY` input 3: raw push buttons `KEY[3:1]`, asynchronous, 0 = pressed.
- `address` input XLEN: MEM-stage byte address (ALU result).
- `read_enable` input 1: MEM-stage load.
- `write_enable` input 1: MEM-stage store.
- `write_data` input XLEN: store data.
- `read_data` output XLEN: register contents, combinational from `address`.
- `read_hit` output 1: `address` decodes to one of this block's registers.

## Operation
- Register map; all unused bits read as 0.
  - 0x4000_0100 SW_LEVEL (RO): bits [9:0] hold the debounced switch levels.
  - 0x4000_0200 KEY_LEVEL (RO): bits [2:0] hold the debounced pressed state, 1 = pressed (inverted from `KEY`).
  - 0x4000_0204 KEY_EDGE (W1C): bits [2:0] are sticky press events.
  - 0x4000_0208 SW_EDGE (W1C): bits [9:0] are sticky change events, set on either direction.
- Synchroniser: two flops per pin. Reset values: `SW` chain 0, `KEY` chain 1 (released).
- Tick counter: counts 0..`DEBOUNCE_CYCLES`-1 and wraps to 0. `tick` = 1 for one cycle when the counter equals `DEBOUNCE_CYCLES`-1.
- Debounce, per bit, on `tick`:
  - `samp` <= synced value.
  - If synced == `samp`, then `deb` <= synced.
  - A level is therefore accepted only after it is equal at two consecutive ticks. A glitch shorter than one tick period is never accepted.
- Arming FSM: states DISARMED and ARMED.
  - Reset enters DISARMED.
  - The second `tick` after reset moves to ARMED, which is terminal until reset.
  - Edge flags update only in ARMED, so switches that are on at power-up do not raise SW_EDGE.
- Edge capture, in ARMED, on the cycle `deb` changes:
  - SW_EDGE[i] is set on any change of switch `deb[i]`.
  - KEY_EDGE[i] is set on a 0→1 change of pressed `deb[i]`.
- W1C: when `write_enable` is high and `address` hits an EDGE register, each bit with `write_data[i]`=1 is cleared.
- Same-cycle set and clear of one bit: set wins and the flag stays 1.
- Writes to SW_LEVEL, KEY_LEVEL or unmapped addresses are ignored.
- Reads have no side effects; clearing is done only by W1C.
- `read_data`/`read_hit` depend only on `address`; `read_enable` gates nothing internally. When `read_hit` = 0, `read_data` = 0.
- Reset values: all `samp`/`deb` 0 (KEY pressed state 0), all edge flags 0, tick counter 0, FSM DISARMED, `read_hit` 0 when `address` is unmapped.
- An asynchronous reset mid-debounce discards all partial state.

## Timing
- Read latency: 0 cycles, combinational from registered state. The register value visible on the MEM-stage cycle of the load is the value returned.
- Write effect: the EDGE flag is 0 starting the cycle after the store.
- Pin-to-`deb` latency: 2 sync cycles plus between 1 and 2 tick periods (the level must be seen at two consecutive ticks).
- Edge flag rises in the same cycle `deb` is written, i.e. it is visible the clock after the accepting tick.
- Tick period is exactly `DEBOUNCE_CYCLES` clocks, independent of pin activity.

## Structure
- Shared header constants, alongside `XLEN`:
  - MMIO page 20'h40000;
  - offsets 12'h100, 12'h200, 12'h204, 12'h208;
  - SW width 10, KEY width 3.
- One sub-module: `input_debouncer`. It is parameterised by width and contains the sync chain, `samp` and `deb`, and takes `tick` as an input.
- Instantiate it twice (SW, KEY) in `mmio_input_port`, with one shared tick counter.
- The top level holds the arming FSM, the edge registers and the address decode.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset with `SW`=10'h3FF and `KEY`=3'b111:
  - after reset, a read of 0x4000_0100 gives 0;
  - after 12 cycles it gives 0x3FF;
  - SW_EDGE reads 0 because the FSM was still DISARMED.
- After ARMED, pull `KEY[1]` low for 12 cycles:
  - KEY_LEVEL goes to 0x1, then 0x0 after release;
  - KEY_EDGE = 0x1 and stays 0x1 after release.
- 2-cycle low glitch on `KEY[2]`, placed between ticks: KEY_LEVEL and KEY_EDGE both stay 0.
- Store 0x1 to 0x4000_0204 with KEY_EDGE = 0x3: the next cycle KEY_EDGE = 0x2. A store of 0x0 changes nothing.
- A W1C of SW_EDGE bit 0 in the same cycle bit 0 sets: SW_EDGE[0] reads 1 afterwards.
- Read 0x4000_0300 or 0x1000_0000: `read_hit` = 0 and `read_data` = 0. A store to 0x4000_0100 leaves SW_LEVEL unchanged.
- Assert `reset` asynchronously while `KEY[1]` is held pressed mid-debounce:
  - all registers read 0 immediately;
  - KEY_EDGE stays 0 through re-arming.

Source files
------------

// File: rtl/mmio_input_port_pkg.sv
// Shared constants, register map and address decode for the board input peripheral.
package mmio_input_port_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned SW_W  = 10;
  localparam int unsigned KEY_W = 3;

  localparam logic [19:0] MMIO_PAGE     = 20'h40000;
  localparam logic [11:0] OFF_SW_LEVEL  = 12'h100;
  localparam logic [11:0] OFF_KEY_LEVEL = 12'h200;
  localparam logic [11:0] OFF_KEY_EDGE  = 12'h204;
  localparam logic [11:0] OFF_SW_EDGE   = 12'h208;

  typedef enum logic {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } arm_state_e;

  typedef enum logic [1:0] {
    REG_SW_LEVEL  = 2'd0,
    REG_KEY_LEVEL = 2'd1,
    REG_KEY_EDGE  = 2'd2,
    REG_SW_EDGE   = 2'd3
  } reg_sel_e;

  typedef struct packed {
    logic     hit;
    reg_sel_e sel;
  } reg_dec_t;

  // Exact word-address match inside the MMIO page.
  function automatic reg_dec_t decode(input logic [XLEN-1:0] addr);
    reg_dec_t d;
    d.hit = 1'b0;
    d.sel = REG_SW_LEVEL;
    if (addr[XLEN-1:12] == MMIO_PAGE) begin
      case (addr[11:0])
        OFF_SW_LEVEL:  begin d.hit = 1'b1; d.sel = REG_SW_LEVEL;  end
        OFF_KEY_LEVEL: begin d.hit = 1'b1; d.sel = REG_KEY_LEVEL; end
        OFF_KEY_EDGE:  begin d.hit = 1'b1; d.sel = REG_KEY_EDGE;  end
        OFF_SW_EDGE:   begin d.hit = 1'b1; d.sel = REG_SW_EDGE;   end
        default:       d.hit = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus two-tick agreement debouncer for W pins.
// INVERT flips the pin polarity so samp/deb always hold the active (1 = on/pressed) sense.
module input_debouncer #(
  parameter int unsigned W      = 1,
  parameter bit          INVERT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [W-1:0] pin_i,
  output logic [W-1:0] deb_o,
  output logic [W-1:0] deb_nxt_c
);

  localparam logic [W-1:0] SYNC_RST = {W{INVERT}};

  logic [W-1:0] sync1_q, sync1_d;
  logic [W-1:0] sync2_q, sync2_d;
  logic [W-1:0] samp_q, samp_d;
  logic [W-1:0] deb_q, deb_d;
  logic [W-1:0] synced_c;
  logic [W-1:0] diff_c;

  always_comb begin
    sync1_d  = pin_i;
    sync2_d  = sync1_q;
    synced_c = sync2_q ^ SYNC_RST;
    diff_c   = synced_c ^ samp_q;
    samp_d   = samp_q;
    deb_d    = deb_q;
    // Accept a bit only when it matches the previous tick's sample.
    if (tick) begin
      samp_d = synced_c;
      deb_d  = (~diff_c & synced_c) | (diff_c & deb_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      samp_q  <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_o     = deb_q;
  assign deb_nxt_c = deb_d;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped read port for debounced switches/keys with sticky W1C edge flags.
module mmio_input_port
  import mmio_input_port_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SW_W-1:0]  SW,
  input  logic [KEY_W-1:0] KEY,
  input  logic [XLEN-1:0]  address,
  input  logic             read_enable,
  input  logic             write_enable,
  input  logic [XLEN-1:0]  write_data,
  output logic [XLEN-1:0]  read_data,
  output logic             read_hit
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;
  arm_state_e       state_q, state_d;
  logic             first_tick_q, first_tick_d;
  logic [SW_W-1:0]  sw_edge_q, sw_edge_d;
  logic [KEY_W-1:0] key_edge_q, key_edge_d;
  logic [SW_W-1:0]  sw_deb, sw_nxt;
  logic [KEY_W-1:0] key_deb, key_nxt;
  reg_dec_t         dec_c;
  logic             unused_c;

  assign unused_c = ^{read_enable, write_data[XLEN-1:SW_W]};

  input_debouncer #(.W(SW_W), .INVERT(1'b0)) u_sw_deb (
    .clk(clock), .rst_n(reset), .tick(tick_c),
    .pin_i(SW), .deb_o(sw_deb), .deb_nxt_c(sw_nxt)
  );

  input_debouncer #(.W(KEY_W), .INVERT(1'b1)) u_key_deb (
    .clk(clock), .rst_n(reset), .tick(tick_c),
    .pin_i(KEY), .deb_o(key_deb), .deb_nxt_c(key_nxt)
  );

  // Free-running tick counter shared by both debouncers.
  always_comb begin
    tick_c = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
  end

  // Arm after the second tick so power-up levels never register as edges.
  always_comb begin
    state_d      = state_q;
    first_tick_d = first_tick_q;
    case (state_q)
      DISARMED: begin
        if (tick_c) begin
          if (first_tick_q) state_d = ARMED;
          else              first_tick_d = 1'b1;
        end
      end
      ARMED:    state_d = ARMED;
    endcase
  end

  assign dec_c = decode(address);

  // Sticky flags: new events win over a same-cycle W1C.
  always_comb begin
    logic [SW_W-1:0]  sw_clr, sw_set;
    logic [KEY_W-1:0] key_clr, key_set;
    sw_clr  = '0;
    key_clr = '0;
    sw_set  = '0;
    key_set = '0;
    if (write_enable && dec_c.hit && dec_c.sel == REG_SW_EDGE)  sw_clr  = write_data[SW_W-1:0];
    if (write_enable && dec_c.hit && dec_c.sel == REG_KEY_EDGE) key_clr = write_data[KEY_W-1:0];
    if (state_q == ARMED) begin
      sw_set  = sw_nxt ^ sw_deb;
      key_set = key_nxt & ~key_deb;
    end
    sw_edge_d  = (sw_edge_q & ~sw_clr) | sw_set;
    key_edge_d = (key_edge_q & ~key_clr) | key_set;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      state_q      <= DISARMED;
      first_tick_q <= 1'b0;
      sw_edge_q    <= '0;
      key_edge_q   <= '0;
    end else begin
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      first_tick_q <= first_tick_d;
      sw_edge_q    <= sw_edge_d;
      key_edge_q   <= key_edge_d;
    end
  end

  always_comb begin
    read_data = '0;
    read_hit  = dec_c.hit;
    if (dec_c.hit) begin
      case (dec_c.sel)
        REG_SW_LEVEL:  read_data = XLEN'(sw_deb);
        REG_KEY_LEVEL: read_data = XLEN'(key_deb);
        REG_KEY_EDGE:  read_data = XLEN'(key_edge_q);
        REG_SW_EDGE:   read_data = XLEN'(sw_edge_q);
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_input_port.sv
// Directed bench for mmio_input_port with DEBOUNCE_CYCLES = 4.
module tb_mmio_input_port;

  logic        clock;
  logic        reset;
  logic [9:0]  SW;
  logic [2:0]  KEY;
  logic [31:0] address;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        read_hit;

  int tests = 0;
  int fails = 0;
  int cyc;

  localparam logic [31:0] A_SWL = 32'h4000_0100;
  localparam logic [31:0] A_KYL = 32'h4000_0200;
  localparam logic [31:0] A_KYE = 32'h4000_0204;
  localparam logic [31:0] A_SWE = 32'h4000_0208;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_hit;
  } vec_t;

  vec_t tbl[15];

  mmio_input_port #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .SW(SW), .KEY(KEY),
    .address(address), .read_enable(read_enable), .write_enable(write_enable),
    .write_data(write_data), .read_data(read_data), .read_hit(read_hit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Clocks since reset release; ticks land on posedges where cyc % 4 == 0.
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp,
                    input logic exp_hit);
    address     = a;
    read_enable = 1'b1;
    #1;
    chk(nm, read_data, exp);
    chk({nm, "_hit"}, 32'(read_hit), 32'(exp_hit));
    read_enable = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic align(input int ph);
    do begin
      @(posedge clock);
      #1;
    end while (cyc % 4 != ph);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address      = a;
    write_data   = d;
    write_enable = 1'b1;
    @(posedge clock);
    #1;
    write_enable = 1'b0;
  endtask

  initial begin
    // Steady-state register map vectors: start SW_LEVEL=3FF, KEY_EDGE=3, SW_EDGE=0.
    tbl[0]  = '{A_SWL,          1'b0, 32'h0,         32'h3FF, 1'b1};
    tbl[1]  = '{A_KYL,          1'b0, 32'h0,         32'h0,   1'b1};
    tbl[2]  = '{A_KYE,          1'b0, 32'h0,         32'h3,   1'b1};
    tbl[3]  = '{A_SWE,          1'b0, 32'h0,         32'h0,   1'b1};
    tbl[4]  = '{A_KYE,          1'b1, 32'h0,         32'h3,   1'b1};
    tbl[5]  = '{A_KYE,          1'b0, 32'h0,         32'h3,   1'b1};
    tbl[6]  = '{A_KYE,          1'b1, 32'h1,         32'h3,   1'b1};
    tbl[7]  = '{A_KYE,          1'b0, 32'h0,         32'h2,   1'b1};
    tbl[8]  = '{32'h4000_0300,  1'b0, 32'h0,         32'h0,   1'b0};
    tbl[9]  = '{32'h1000_0000,  1'b0, 32'h0,         32'h0,   1'b0};
    tbl[10] = '{A_SWL,          1'b1, 32'hFFFF_FFFF, 32'h3FF, 1'b1};
    tbl[11] = '{A_KYL,          1'b1, 32'hFFFF_FFFF, 32'h0,   1'b1};
    tbl[12] = '{32'h4000_0300,  1'b1, 32'hFFFF_FFFF, 32'h0,   1'b0};
    tbl[13] = '{A_KYE,          1'b1, 32'hFFFF_FFF2, 32'h2,   1'b1};
    tbl[14] = '{A_KYE,          1'b0, 32'h0,         32'h0,   1'b1};

    reset        = 1'b0;
    SW           = 10'h3FF;
    KEY          = 3'b111;
    address      = A_SWL;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    write_data   = '0;
    #1;
    rd("in_reset_sw_level", A_SWL, 32'h0, 1'b1);
    rd("in_reset_unmapped", 32'h4000_0300, 32'h0, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    rd("post_reset_sw_level", A_SWL, 32'h0, 1'b1);
    wait_cyc(12);
    rd("powerup_sw_level", A_SWL, 32'h3FF, 1'b1);
    rd("powerup_sw_edge", A_SWE, 32'h0, 1'b1);
    rd("powerup_key_level", A_KYL, 32'h0, 1'b1);

    // KEY[1] press held for 12 cycles, then released.
    align(0);
    KEY = 3'b110;
    wait_cyc(7);
    rd("key1_not_yet", A_KYL, 32'h0, 1'b1);
    wait_cyc(5);
    rd("key1_level", A_KYL, 32'h1, 1'b1);
    rd("key1_edge", A_KYE, 32'h1, 1'b1);
    KEY = 3'b111;
    wait_cyc(12);
    rd("key1_released_level", A_KYL, 32'h0, 1'b1);
    rd("key1_released_edge", A_KYE, 32'h1, 1'b1);

    // Two-cycle glitch on KEY[2], straddling no sampled tick.
    align(3);
    KEY = 3'b101;
    wait_cyc(2);
    KEY = 3'b111;
    wait_cyc(12);
    rd("glitch_level", A_KYL, 32'h0, 1'b1);
    rd("glitch_edge", A_KYE, 32'h1, 1'b1);

    // Real KEY[2] press so KEY_EDGE becomes 0x3.
    align(0);
    KEY = 3'b101;
    wait_cyc(12);
    rd("key2_level", A_KYL, 32'h2, 1'b1);
    KEY = 3'b111;
    wait_cyc(12);

    for (int i = 0; i < 15; i++) begin
      address     = tbl[i].addr;
      write_data  = tbl[i].wdata;
      read_enable = ~tbl[i].we;
      #1;
      chk($sformatf("vec%0d_data", i), read_data, tbl[i].exp_data);
      chk($sformatf("vec%0d_hit", i), 32'(read_hit), 32'(tbl[i].exp_hit));
      write_enable = tbl[i].we;
      @(posedge clock);
      #1;
      write_enable = 1'b0;
      read_enable  = 1'b0;
    end

    // SW[0] falls; W1C of SW_EDGE[0] lands on the very cycle the flag sets.
    align(0);
    SW = 10'h3FE;
    wait_cyc(7);
    rd("sw0_before_set", A_SWE, 32'h0, 1'b1);
    wr(A_SWE, 32'h1);
    rd("sw0_set_beats_clear", A_SWE, 32'h1, 1'b1);
    rd("sw0_level", A_SWL, 32'h3FE, 1'b1);
    wr(A_SWE, 32'h1);
    rd("sw0_w1c", A_SWE, 32'h0, 1'b1);
    align(0);
    SW = 10'h3FF;
    wait_cyc(12);
    rd("sw0_rise_edge", A_SWE, 32'h1, 1'b1);

    // Asynchronous reset while KEY[1] is mid-debounce.
    align(0);
    KEY = 3'b110;
    wait_cyc(5);
    #2;
    reset = 1'b0;
    rd("rst_sw_level", A_SWL, 32'h0, 1'b1);
    rd("rst_key_level", A_KYL, 32'h0, 1'b1);
    rd("rst_key_edge", A_KYE, 32'h0, 1'b1);
    rd("rst_sw_edge", A_SWE, 32'h0, 1'b1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    wait_cyc(12);
    rd("rearm_key_level", A_KYL, 32'h1, 1'b1);
    rd("rearm_key_edge", A_KYE, 32'h0, 1'b1);
    wait_cyc(8);
    rd("rearm_key_edge_late", A_KYE, 32'h0, 1'b1);
    rd("rearm_sw_level", A_SWL, 32'h3FF, 1'b1);
    rd("rearm_sw_edge", A_SWE, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
